flags_sequencer: RTL

//  Sequences the flags register: drives its active-low control strobes (boutn, bloadn, calcn)
//  for one flag operation per request, and evaluates a branch condition against fout.

---
 rtl/flags_sequencer_pkg.sv | 48 ++++
 rtl/flags_sequencer_if.sv | 33 +++
 rtl/flags_sequencer_cond_eval.sv | 26 ++
 rtl/flags_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/flags_sequencer_pkg.sv
// Shared definitions for the flags sequencer: op/cond codes, FSM states,
// flag bit positions and the legal parameter ranges.
package flags_seq_pkg;

    // Operation codes
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CALC   = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BR     = 3'b100;
    localparam logic [2:0] OP_CALCBR = 3'b101;

    // Branch condition codes
    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;
    localparam logic [2:0] COND_N      = 3'd5;
    localparam logic [2:0] COND_V      = 3'd6;
    localparam logic [2:0] COND_UGT    = 3'd7;

    // Bit positions inside fout
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Legal parameter ranges
    localparam int STROBE_W_MIN = 1;
    localparam int STROBE_W_MAX = 4;
    localparam int FOUT_LAT_MIN = 0;
    localparam int FOUT_LAT_MAX = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_SETTLE = 3'd2,
        S_EVAL   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Codes 11x have no defined operation
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/flags_sequencer_if.sv
// Request/response bundle between the decoder and the flags sequencer.
// Handshake: start is a request pulse that is accepted only on a rising edge
// where the sequencer is in IDLE; op/cond are captured on that same edge.
// There is no ready signal and no queueing: a start seen while busy or in the
// DONE cycle is dropped. Completion is the one-cycle done pulse; take and err
// are valid while done=1 (take is held until the next accept).
interface flags_sequencer_if;
    import flags_seq_pkg::*;

    logic       start;
    logic [2:0] op;
    logic [2:0] cond;
    logic [3:0] fout;
    logic       boutn;
    logic       bloadn;
    logic       calcn;
    logic       busy;
    logic       done;
    logic       take;
    logic       err;
    state_t     dbg_state;

    modport master (
        output start, op, cond, fout,
        input  boutn, bloadn, calcn, busy, done, take, err, dbg_state
    );

    modport slave (
        input  start, op, cond, fout,
        output boutn, bloadn, calcn, busy, done, take, err, dbg_state
    );

endinterface

// File: rtl/flags_sequencer_cond_eval.sv
// Combinational branch-condition evaluator: maps (cond, fout) to hit.
module flags_cond_eval
    import flags_seq_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] fout,
    output logic       hit
);

    // Decode the condition against the individual flag bits
    always_comb begin
        hit = 1'b0;
        case (cond)
            COND_ALWAYS: hit = 1'b1;
            COND_Z:      hit = fout[FLAG_Z];
            COND_NZ:     hit = ~fout[FLAG_Z];
            COND_C:      hit = fout[FLAG_C];
            COND_NC:     hit = ~fout[FLAG_C];
            COND_N:      hit = fout[FLAG_N];
            COND_V:      hit = fout[FLAG_V];
            COND_UGT:    hit = fout[FLAG_C] & ~fout[FLAG_Z];
            default:     hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_sequencer.sv
// Flags register sequencer: one strobe operation per accepted request, with
// optional settle time and branch evaluation. All outputs are registered from
// the next state, so each output reflects the state it is in this cycle.
module flags_sequencer
    import flags_seq_pkg::*;
#(
    parameter int STROBE_W = 1,
    parameter int FOUT_LAT = 1
) (
    input logic         clk,
    input logic         resetn,
    flags_sequencer_if.slave bus
);

    // Counter reload values; FOUT_LAT=0 never enters SETTLE
    localparam logic [1:0] STROBE_LOAD = 2'(STROBE_W - 1);
    localparam logic [1:0] SETTLE_LOAD = 2'((FOUT_LAT > 0) ? (FOUT_LAT - 1) : 0);

    state_t     state, next_state;
    logic [1:0] cnt;
    logic [2:0] op_q, cond_q, op_sel;
    logic       accept, hit;
    logic       boutn_q, bloadn_q, calcn_q, busy_q, done_q, take_q, err_q;
    logic       boutn_d, bloadn_d, calcn_d, take_d, err_d;

    assign accept = (state == S_IDLE) && bus.start;
    // The op register only updates at the accept edge, so use the live op then
    assign op_sel = accept ? bus.op : op_q;

    flags_cond_eval u_cond_eval (
        .cond (cond_q),
        .fout (bus.fout),
        .hit  (hit)
    );

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_CALC, OP_LOAD, OP_STORE, OP_CALCBR: next_state = S_STROBE;
                        OP_BR:                                 next_state = S_EVAL;
                        default:                               next_state = S_DONE;
                    endcase
                end
            end
            S_STROBE: begin
                if (cnt == 2'd0) begin
                    if (op_q == OP_CALCBR) next_state = (FOUT_LAT == 0) ? S_EVAL : S_SETTLE;
                    else                   next_state = S_DONE;
                end
            end
            S_SETTLE: if (cnt == 2'd0) next_state = S_EVAL;
            S_EVAL:   next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        boutn_d  = 1'b1;
        bloadn_d = 1'b1;
        calcn_d  = 1'b1;
        take_d   = take_q;
        err_d    = err_q;
        if (next_state == S_STROBE) begin
            case (op_sel)
                OP_CALC, OP_CALCBR: calcn_d  = 1'b0;
                OP_LOAD:            bloadn_d = 1'b0;
                OP_STORE:           boutn_d  = 1'b0;
                default:            ;
            endcase
        end
        if (accept) begin
            take_d = 1'b0;
            err_d  = op_is_illegal(bus.op);
        end else if (state == S_EVAL) begin
            take_d = hit;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    // Shared down-counter for strobe width and settle time
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                          cnt <= 2'd0;
        else if (state != S_STROBE && next_state == S_STROBE) cnt <= STROBE_LOAD;
        else if (state != S_SETTLE && next_state == S_SETTLE) cnt <= SETTLE_LOAD;
        else if (cnt != 2'd0)                                 cnt <= cnt - 2'd1;
    end

    // Request capture on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= OP_NOP;
            cond_q <= COND_ALWAYS;
        end else if (accept) begin
            op_q   <= bus.op;
            cond_q <= bus.cond;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            boutn_q  <= 1'b1;
            bloadn_q <= 1'b1;
            calcn_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            take_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            boutn_q  <= boutn_d;
            bloadn_q <= bloadn_d;
            calcn_q  <= calcn_d;
            busy_q   <= (next_state != S_IDLE);
            done_q   <= (next_state == S_DONE);
            take_q   <= take_d;
            err_q    <= err_d;
        end
    end

    assign bus.boutn     = boutn_q;
    assign bus.bloadn    = bloadn_q;
    assign bus.calcn     = calcn_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.take      = take_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state;

endmodule
